seq_det_param: RTL and testbench
================================

# seq_det_param

Parametrised serial bit-pattern detector, the successor to the fixed 5-bit `10010` detector FSM. It sits on a 1-bit serial input stream and pulses `out` for one cycle whenever the last `LEN` accepted bits equal `PATTERN`. Over the fixed detector it adds:
- an `in_valid` qualifier;
- run-time selection between overlapping and non-overlapping matching;
- a synchronous clear;
- an optional saturating match counter.

## Interface
Parameters:
- `LEN`, 5, pattern length in bits; legal range 2..32.
- `PATTERN`, `5'b10010`, `LEN`-bit target; MSB is the oldest bit of the sequence.
- `CNT_W`, 8, width of `match_cnt`.

Ports:
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  `in` is sampled only when high.
- `in`  input  1  serial data bit.
- `overlap`  input  1  1 = overlapping matches allowed; 0 = history discarded after each match.
- `clear`  input  1  synchronous clear of history, fill level and counter.
- `out`  output  1  registered one-cycle match pulse.
- `match_cnt`  output  `CNT_W`  number of matches since reset or clear (see Configuration).

## Operation
State:
- `hist[LEN-1:0]`: shift history.
- `fill`: fill level, 0..`LEN`. This is the FSM state.
  - HUNT states: `fill` < `LEN`-1.
  - ARMED states: `fill` ≥ `LEN`-1, meaning the next accepted bit can complete a match.
- `out` register.
- `match_cnt` register.

Reset (`rst`=0, immediately, without waiting for a clock edge):
- `hist`=0, `fill`=0, `out`=0, `match_cnt`=0.

Per cycle with `clear`=0 and `in_valid`=1:
- Candidate `cand` = {`hist[LEN-2:0]`, `in`}.
- Always: `hist` ← `cand`.
- Match = (`fill` ≥ `LEN`-1) AND (`cand` == `PATTERN`).
- On match:
  - `out` ← 1.
  - `match_cnt` increments, saturating at 2^`CNT_W`-1.
  - `fill` ← `overlap` ? `LEN` : 0.
- Otherwise:
  - `out` ← 0.
  - `fill` ← min(`fill`+1, `LEN`).

Per cycle with `in_valid`=0:
- `out` ← 0; `hist`, `fill` and `match_cnt` hold.

`clear`=1:
- Next edge: `hist`=0, `fill`=0, `out`=0, `match_cnt`=0.
- `clear` has priority over `in_valid`; the simultaneous input bit is dropped.

Partial history never matches. Bits shifted before `fill` reaches `LEN`-1 are ignored, so a reset `hist` of 0 cannot alias a zero-heavy `PATTERN`.

`overlap` is sampled only on the matching cycle and may change freely at any time.

## Timing
- Latency: `out` is high for exactly the cycle after the edge that accepts the completing bit (1-cycle registered latency).
- Back-to-back matches: with `overlap`=1 and a self-overlapping `PATTERN`, the earliest possible next match is the next accepted bit.
  - `out` may stay high on consecutive cycles, with one pulse per match.
- `match_cnt` updates on the same edge as `out` rises.
- Gaps in `in_valid` stretch the sequence without breaking it; there is no timeout.
- `rst` deassertion mid-stream: detection restarts from `fill`=0 on the first accepted bit after release.
- `rst` assertion mid-stream: no output glitch beyond the immediate async clear of all state.

## Configuration
Macro `SEQ_DET_CNT_EN`:
- Defined:
  - The `CNT_W`-bit saturating counter is built.
  - `match_cnt` behaves as in Operation.
- Undefined:
  - No counter flops are built.
  - `match_cnt` is tied to 0.
  - Detection, `out` and `clear` behaviour are otherwise identical.

## Test plan
All scenarios use defaults (`LEN`=5, `PATTERN`=`10010`) and `SEQ_DET_CNT_EN` defined, except scenario 6.

1. Reset and release, then accept `1,0,0,1,0` with `in_valid`=1 → `out`=1 for one cycle after the 5th bit; `match_cnt`=1; `out`=0 at all other times.
2. `overlap`=1, stream `1,0,0,1,0,0,1,0` → pulses after bits 5 and 8; `match_cnt`=2.
3. `overlap`=0, same stream → single pulse after bit 5; no pulse after bit 8; `match_cnt`=1.
4. Stream `1,0,0,1,0` with `in_valid` low for 3 cycles between every bit → exactly one pulse, after the 5th accepted bit.
5. Two disruptions, checked separately:
   - Assert `clear` together with the 5th bit of `10010` → no pulse; `match_cnt`=0; a fresh `10010` then matches.
   - Assert `rst` after 4 bits → `out`=0 and `match_cnt`=0 immediately; the resumed stream needs 5 new bits to match.
6. `CNT_W`=2: six matches → `match_cnt` saturates at 3.
   - Rebuild without `SEQ_DET_CNT_EN` → `match_cnt` stays 0 and the `out` pulses are unchanged.

Source files
------------

// File: rtl/seq_det_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_param
// Description : Parametrised serial bit-pattern detector. Pulses `out` for
//               one cycle whenever the last LEN accepted bits equal PATTERN
//               (MSB = oldest bit). Supports an input qualifier, run-time
//               overlapping / non-overlapping matching, a synchronous clear
//               and an optional saturating match counter.
//
//               Optional feature macro: SEQ_DET_CNT_EN
//                 defined   -> CNT_W-bit saturating match counter is built
//                 undefined -> no counter flops, match_cnt tied to 0
//
// Ports       : clk       - single clock, rising edge
//               rst       - asynchronous reset, active low
//               in_valid  - `in` is sampled only when high
//               in        - serial data bit
//               overlap   - 1: overlapping matches, 0: restart after match
//               clear     - synchronous clear of history, fill and counter
//               out       - registered one-cycle match pulse
//               match_cnt - matches since reset / clear (0 if no counter)
//
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_param #(
    parameter int              LEN     = 5,
    parameter logic [LEN-1:0]  PATTERN = 5'b10010,
    parameter int              CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in,
    input  logic             overlap,
    input  logic             clear,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt
);

    // fill counts accepted bits since reset/clear/non-overlapping match,
    // saturating at LEN. It is the detector state: below LEN-1 we are still
    // hunting, at LEN-1 or above the next accepted bit can complete a match.
    localparam int             FILL_W    = $clog2(LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);
    localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(LEN - 1);

    logic [LEN-1:0]    hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              out_q, out_d;
    logic [LEN-1:0]    cand;
    logic              match;

    always_comb begin
        cand   = {hist_q[LEN-2:0], in};
        // Gating with fill keeps the zeroed reset history from aliasing
        // a zero-heavy pattern.
        match  = in_valid && !clear && (fill_q >= FILL_ARM) && (cand == PATTERN);

        hist_d = hist_q;
        fill_d = fill_q;
        out_d  = 1'b0;

        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            hist_d = cand;
            if (match) begin
                out_d  = 1'b1;
                fill_d = overlap ? FILL_FULL : '0;
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
            out_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            out_q  <= out_d;
        end
    end

    assign out = out_q;

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_det_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_det_param
// Description : Self-checking bench for seq_det_param. A queue-based model
//               of accepted bits predicts out / match_cnt; a compare process
//               checks every falling edge, and directed scenarios add
//               hand-computed literal checks. A second instance with CNT_W=2
//               shares the stimulus to exercise counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_param;

    localparam int LEN = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_b = 1'b0;
    logic       overlap = 1'b0;
    logic       clear = 1'b0;
    logic       out1, out2;
    logic [7:0] cnt1;
    logic [1:0] cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    bit   bits[$];
    bit   exp_out  = 1'b0;
    int   exp_cnt  = 0;
    int   exp_cnt2 = 0;
    logic [LEN-1:0] pat = 5'b10010;
    bit   started = 1'b0;

    seq_det_param #(.LEN(5), .PATTERN(5'b10010), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_b),
        .overlap(overlap), .clear(clear), .out(out1), .match_cnt(cnt1)
    );

    seq_det_param #(.LEN(5), .PATTERN(5'b10010), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_b),
        .overlap(overlap), .clear(clear), .out(out2), .match_cnt(cnt2)
    );

    always #5 clk = ~clk;

    // Counter value visible at the port for the current build.
    function automatic int vis(input int c);
`ifdef SEQ_DET_CNT_EN
        return c;
`else
        return 0 * c;
`endif
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        bits.delete();
        exp_out  = 1'b0;
        exp_cnt  = 0;
        exp_cnt2 = 0;
    endtask

    // One clock of stimulus; model advances on the same edge.
    task automatic step(input bit v, input bit b, input bit ov, input bit clr);
        bit ok;
        in_valid = v; in_b = b; overlap = ov; clear = clr;
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else if (v) begin
            bits.push_back(b);
            exp_out = 1'b0;
            if (bits.size() >= LEN) begin
                ok = 1'b1;
                for (int i = 0; i < LEN; i++)
                    if (bits[bits.size() - LEN + i] != pat[LEN-1-i]) ok = 1'b0;
                if (ok) begin
                    exp_out = 1'b1;
                    if (exp_cnt  < 255) exp_cnt++;
                    if (exp_cnt2 < 3)   exp_cnt2++;
                    if (!ov) bits.delete();
                end
            end
            while (bits.size() > LEN) void'(bits.pop_front());
        end else begin
            exp_out = 1'b0;
        end
        #2;
        in_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic send(input bit b, input bit ov);
        step(1'b1, b, ov, 1'b0);
    endtask

    // Compare process: every falling edge, outputs vs model.
    always @(negedge clk) begin
        if (started) begin
            chk("out",   int'(out1), int'(exp_out));
            chk("out2",  int'(out2), int'(exp_out));
            chk("cnt",   int'(cnt1), vis(exp_cnt));
            chk("cnt2",  int'(cnt2), vis(exp_cnt2));
        end
    end

    initial begin
        // reset state
        #1;
        chk("reset_out", int'(out1), 0);
        chk("reset_cnt", int'(cnt1), 0);
        started = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        // 1: single match
        send(1, 1); send(0, 1); send(0, 1); send(1, 1);
        chk("s1_before", int'(out1), 0);
        send(0, 1);
        chk("s1_pulse", int'(out1), 1);
        chk("s1_cnt",   int'(cnt1), vis(1));
        step(0, 0, 1, 0);
        chk("s1_after", int'(out1), 0);

        // 2: overlapping 10010010
        step(0, 0, 1, 1);
        send(1,1); send(0,1); send(0,1); send(1,1); send(0,1);
        chk("s2_p1", int'(out1), 1);
        send(0,1); send(1,1);
        chk("s2_gap", int'(out1), 0);
        send(0,1);
        chk("s2_p2",  int'(out1), 1);
        chk("s2_cnt", int'(cnt1), vis(2));

        // 3: non-overlapping, same stream
        step(0, 0, 0, 1);
        send(1,0); send(0,0); send(0,0); send(1,0); send(0,0);
        chk("s3_p1", int'(out1), 1);
        send(0,0); send(1,0); send(0,0);
        chk("s3_nop2", int'(out1), 0);
        chk("s3_cnt",  int'(cnt1), vis(1));

        // 4: in_valid gaps of 3 cycles
        step(0, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            bit bv;
            bv = pat[4-i];
            send(bv, 1);
            if (i == 4) chk("s4_pulse", int'(out1), 1);
            for (int g = 0; g < 3; g++) step(0, 1, 1, 0);
        end
        chk("s4_cnt", int'(cnt1), vis(1));

        // 5a: clear with the completing bit
        step(0, 0, 1, 1);
        send(1,1); send(0,1); send(0,1); send(1,1);
        step(1, 0, 1, 1);
        chk("s5a_nopulse", int'(out1), 0);
        chk("s5a_cnt",     int'(cnt1), 0);
        send(1,1); send(0,1); send(0,1); send(1,1); send(0,1);
        chk("s5a_fresh", int'(out1), 1);

        // 5b: async reset after 4 bits (counter is 1 beforehand)
        send(1,1); send(0,1); send(0,1); send(1,1);
        rst = 1'b0;
        #1;
        model_reset();
        chk("s5b_out_async", int'(out1), 0);
        chk("s5b_cnt_async", int'(cnt1), 0);
        @(negedge clk);
        rst = 1'b1;
        send(0,1);
        chk("s5b_nostale", int'(out1), 0);
        send(1,1); send(0,1); send(0,1); send(1,1); send(0,1);
        chk("s5b_rematch", int'(out1), 1);

        // 6: six overlapping matches; CNT_W=2 saturates at 3
        step(0, 0, 1, 1);
        send(1,1); send(0,1);
        for (int k = 0; k < 6; k++) begin
            send(0,1); send(1,1); send(0,1);
            chk("s6_pulse", int'(out1), 1);
        end
        chk("s6_cnt8", int'(cnt1), vis(6));
        chk("s6_cnt2", int'(cnt2), vis(3));
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        started = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
